// File: rtl/simd_alu_pkg.sv
// Shared types and constants for the SIMD ALU mask scanner slice.
package simd_alu_pkg;
  localparam int SIMD_DATA_WIDTH            = 256;
  localparam int SIMD_ADDER_DATA_MODE_WIDTH = 2;
  localparam int MAX_LANES                  = SIMD_DATA_WIDTH / 8;
  localparam int LANE_IDX_W                 = $clog2(MAX_LANES);

  typedef enum logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] {
    MODE_8  = 2'd0,
    MODE_16 = 2'd1,
    MODE_32 = 2'd2,
    MODE_64 = 2'd3
  } simd_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;
  typedef logic [LANE_IDX_W:0]   lane_cnt_t;

  function automatic lane_cnt_t popcount(input logic [MAX_LANES-1:0] v);
    lane_cnt_t c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + lane_cnt_t'(v[i]);
    end
    return c;
  endfunction
endpackage

// File: rtl/simd_alu_lane_prio_enc.sv
// Lowest-set-bit priority encoder over the per-lane match vector.
module simd_alu_lane_prio_enc
  import simd_alu_pkg::*;
(
  input  logic [MAX_LANES-1:0] req,
  output lane_idx_t            idx,
  output logic                 any,
  output logic [MAX_LANES-1:0] onehot
);

  // Scan from the top so the lowest set bit is the final winner.
  always_comb begin
    idx = '0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      idx = req[i] ? lane_idx_t'(i) : idx;
    end
  end

  assign any    = |req;
  assign onehot = req & (~req + {{(MAX_LANES-1){1'b0}}, 1'b1});

endmodule

// File: rtl/simd_alu_mask_scanner.sv
// Turns a per-lane compare mask into a valid/ready stream of matching lane indices,
// lowest lane first; one mask is held until its last index is consumed.
module simd_alu_mask_scanner
  import simd_alu_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [SIMD_DATA_WIDTH-1:0]            in_mask,
  input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] in_data_mode,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output lane_idx_t                             out_lane_idx,
  output logic                                  out_last,
  output logic                                  out_empty,
  output lane_cnt_t                             out_count
);

  scan_state_e          state_q, state_d;
  logic [MAX_LANES-1:0] pending_q, pending_d;
  lane_cnt_t            count_q, count_d;
  logic [MAX_LANES-1:0] lane_bits;
  logic [MAX_LANES-1:0] hit_onehot;
  lane_idx_t            hit_idx;
  logic                 hit_any;
  logic                 last_beat;
  logic                 unused_mask_bits;

  // Only bit 0 of each lane is the compare result; lanes beyond the mode's count stay 0.
  always_comb begin
    lane_bits = '0;
    case (simd_mode_e'(in_data_mode))
      MODE_8:  for (int k = 0; k < MAX_LANES;     k++) lane_bits[k] = in_mask[k*8];
      MODE_16: for (int k = 0; k < MAX_LANES / 2; k++) lane_bits[k] = in_mask[k*16];
      MODE_32: for (int k = 0; k < MAX_LANES / 4; k++) lane_bits[k] = in_mask[k*32];
      MODE_64: for (int k = 0; k < MAX_LANES / 8; k++) lane_bits[k] = in_mask[k*64];
      default: lane_bits = '0;
    endcase
  end

  assign unused_mask_bits = ^in_mask;

  simd_alu_lane_prio_enc u_prio_enc (
    .req    (pending_q),
    .idx    (hit_idx),
    .any    (hit_any),
    .onehot (hit_onehot)
  );

  // Zero or one bit left means the current beat closes the mask.
  assign last_beat = (pending_q == hit_onehot);

  // Next-state: accept in IDLE, retire the lowest pending lane on each handshake in SCAN.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_SCAN;
          pending_d = lane_bits;
          count_d   = popcount(lane_bits);
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (out_ready) begin
          pending_d = pending_q & ~hit_onehot;
          state_d   = last_beat ? ST_IDLE : ST_SCAN;
        end else begin
          state_d   = ST_SCAN;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
      end
    endcase
  end

  // State, pending lanes and match count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_SCAN);
  assign out_lane_idx = hit_idx;
  assign out_last     = (state_q == ST_SCAN) && last_beat;
  assign out_empty    = (state_q == ST_SCAN) && !hit_any;
  assign out_count    = count_q;

endmodule

// File: tb/tb_simd_alu_mask_scanner.sv
// Randomized and directed bench for simd_alu_mask_scanner against a lane-list reference model.
module tb_simd_alu_mask_scanner;
  import simd_alu_pkg::*;

  logic                                  clk = 1'b0;
  logic                                  rst;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [SIMD_DATA_WIDTH-1:0]            in_mask;
  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] in_data_mode;
  logic                                  out_valid;
  logic                                  out_ready;
  lane_idx_t                             out_lane_idx;
  logic                                  out_last;
  logic                                  out_empty;
  lane_cnt_t                             out_count;

  int checks   = 0;
  int failures = 0;

  simd_alu_mask_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mask      (in_mask),
    .in_data_mode (in_data_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane_idx (out_lane_idx),
    .out_last     (out_last),
    .out_empty    (out_empty),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: list of matching lanes from the bit-0-of-lane rule.
  task automatic model_lanes(input logic [SIMD_DATA_WIDTH-1:0] m, input logic [1:0] md,
                             output int lanes[$]);
    int w;
    int n;
    lanes.delete();
    w = 8 << md;
    n = SIMD_DATA_WIDTH / w;
    for (int j = 0; j < n; j++) begin
      if (m[j*w]) lanes.push_back(j);
    end
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after the last beat.
  // rdy_mode: 0 always ready, 1 toggling 1/0, 2 random.
  task automatic send_mask(input logic [SIMD_DATA_WIDTH-1:0] m, input logic [1:0] md,
                           input int rdy_mode, input bit hold_next,
                           input logic [SIMD_DATA_WIDTH-1:0] nm, input logic [1:0] nmd);
    int exp_q[$];
    int cnt;
    int beats;
    int k;
    int cyc;
    int guard;
    bit r;
    model_lanes(m, md, exp_q);
    cnt   = exp_q.size();
    beats = (cnt == 0) ? 1 : cnt;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid     = 1'b1;
    in_mask      = m;
    in_data_mode = md;
    out_ready    = 1'b0;
    @(negedge clk);
    if (hold_next) begin
      in_mask      = nm;
      in_data_mode = nmd;
    end else begin
      in_valid = 1'b0;
    end
    k   = 0;
    cyc = 0;
    while (k < beats && cyc < 400) begin
      check_eq("out_valid", 32'(out_valid), 32'd1);
      check_eq("in_ready_scan", 32'(in_ready), 32'd0);
      check_eq("lane_idx", 32'(out_lane_idx), (cnt == 0) ? 32'd0 : 32'(exp_q[k]));
      check_eq("last", 32'(out_last), 32'(k == beats - 1));
      check_eq("empty", 32'(out_empty), 32'(cnt == 0));
      check_eq("count", 32'(out_count), 32'(cnt));
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      @(negedge clk);
      cyc++;
      if (r) k++;
    end
    if (k < beats) check_eq("beat_timeout", 32'(k), 32'(beats));
    out_ready = 1'b0;
    check_eq("idle_valid", 32'(out_valid), 32'd0);
    check_eq("idle_ready", 32'(in_ready), 32'd1);
    check_eq("idle_last", 32'(out_last), 32'd0);
  endtask

  initial begin
    logic [SIMD_DATA_WIDTH-1:0] m;
    logic [SIMD_DATA_WIDTH-1:0] m2;
    logic [SIMD_DATA_WIDTH-1:0] m3;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_mask      = '0;
    in_data_mode = 2'd0;
    out_ready    = 1'b0;
    #12;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_last", 32'(out_last), 32'd0);
    check_eq("rst_empty", 32'(out_empty), 32'd0);
    check_eq("rst_idx", 32'(out_lane_idx), 32'd0);
    check_eq("rst_count", 32'(out_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 8-bit lanes 0, 5, 31
    m = '0; m[0] = 1'b1; m[40] = 1'b1; m[248] = 1'b1;
    send_mask(m, 2'd0, 0, 1'b0, '0, 2'd0);

    // 64-bit lanes, no matches
    send_mask('0, 2'd3, 2, 1'b0, '0, 2'd0);

    // 16-bit lanes all matching, plus an upper lane bit that must be ignored
    m = '0;
    for (int j = 0; j < 16; j++) m[j*16] = 1'b1;
    m[8] = 1'b1;
    send_mask(m, 2'd1, 1, 1'b0, '0, 2'd0);

    // 32-bit lanes: lane 3 has bit 0 clear, lane 6 set
    m = '0; m[127:97] = '1; m[192] = 1'b1;
    send_mask(m, 2'd2, 0, 1'b0, '0, 2'd0);

    // Async reset after 2 of 4 beats
    m = '0; m[8] = 1'b1; m[16] = 1'b1; m[72] = 1'b1; m[160] = 1'b1;
    in_valid = 1'b1; in_mask = m; in_data_mode = 2'd0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("pre_rst_idx0", 32'(out_lane_idx), 32'd1);
    @(negedge clk);
    check_eq("pre_rst_idx1", 32'(out_lane_idx), 32'd2);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("pre_rst_idx2", 32'(out_lane_idx), 32'd9);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_count", 32'(out_count), 32'd0);
    check_eq("mid_rst_idx", 32'(out_lane_idx), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);
    check_eq("post_rst_valid", 32'(out_valid), 32'd0);
    m = '0; m[24] = 1'b1; m[200] = 1'b1;
    send_mask(m, 2'd0, 2, 1'b0, '0, 2'd0);

    // in_valid held during SCAN with the next mask, then back-to-back masks
    m  = '0; m[0] = 1'b1; m[64] = 1'b1; m[128] = 1'b1;
    m2 = '0; m2[32] = 1'b1; m2[96] = 1'b1;
    m3 = '0; m3[16] = 1'b1;
    send_mask(m, 2'd3, 1, 1'b1, m2, 2'd2);
    send_mask(m2, 2'd2, 0, 1'b1, m3, 2'd1);
    send_mask(m3, 2'd1, 0, 1'b0, '0, 2'd0);

    // Random masks of varied density and mode
    for (int t = 0; t < 30; t++) begin
      for (int w = 0; w < SIMD_DATA_WIDTH / 32; w++) begin
        case (t % 3)
          0:       m[w*32 +: 32] = $urandom();
          1:       m[w*32 +: 32] = $urandom() & $urandom() & $urandom();
          default: m[w*32 +: 32] = (t % 2 == 0) ? 32'h0 : ($urandom() | $urandom());
        endcase
      end
      send_mask(m, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, '0, 2'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
